// File: rtl/gate_arbiter.sv
// Parking barrier arbiter: grants the shared barrier to the entry or exit side,
// sequences the motor and pulses the occupancy counter once a vehicle has passed.
module gate_arbiter #(
    parameter int unsigned OPEN_CYCLES  = 4,
    parameter int unsigned PASS_TIMEOUT = 16,
    parameter int unsigned CLOSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_in,
    input  logic       req_out,
    input  logic       pass_done,
    input  logic [2:0] count,
    input  logic       lleno,
    output logic       grant_in,
    output logic       grant_out,
    output logic       motor_up,
    output logic       motor_down,
    output logic       gate_is_open,
    output logic       inc,
    output logic       dec,
    output logic       reject,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       grant_in_q, grant_in_d;
    logic       grant_out_q, grant_out_d;
    logic       last_in_q, last_in_d;
    logic       req_in_prev_q;
    logic       motor_up_q, motor_down_q, open_q;
    logic       inc_q, inc_d, dec_q, dec_d, reject_q;
    logic       vin, vout;

    assign vin  = req_in & ~lleno;
    assign vout = req_out & (count != 3'd0);

    // Outputs like the motor drives are derived from the next state so that
    // they are registered yet line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 8'd1;
        grant_in_d  = grant_in_q;
        grant_out_d = grant_out_q;
        last_in_d   = last_in_q;
        inc_d       = 1'b0;
        dec_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (vin && (!vout || !last_in_q)) begin
                    grant_in_d = 1'b1;
                    last_in_d  = 1'b1;
                    state_d    = OPENING;
                end else if (vout) begin
                    grant_out_d = 1'b1;
                    last_in_d   = 1'b0;
                    state_d     = OPENING;
                end
            end
            OPENING: begin
                if (timer_q == 8'(OPEN_CYCLES - 1)) state_d = OPEN;
            end
            OPEN: begin
                // A pass in the last timeout cycle still counts the vehicle.
                if (pass_done) begin
                    inc_d   = grant_in_q;
                    dec_d   = grant_out_q;
                    state_d = CLOSING;
                end else if (timer_q == 8'(PASS_TIMEOUT - 1)) begin
                    state_d = CLOSING;
                end
            end
            CLOSING: begin
                if (timer_q == 8'(CLOSE_CYCLES - 1)) begin
                    state_d     = IDLE;
                    grant_in_d  = 1'b0;
                    grant_out_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q || state_q == IDLE) timer_d = 8'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= 8'd0;
            grant_in_q    <= 1'b0;
            grant_out_q   <= 1'b0;
            last_in_q     <= 1'b1;
            req_in_prev_q <= 1'b0;
            motor_up_q    <= 1'b0;
            motor_down_q  <= 1'b0;
            open_q        <= 1'b0;
            inc_q         <= 1'b0;
            dec_q         <= 1'b0;
            reject_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            grant_in_q    <= grant_in_d;
            grant_out_q   <= grant_out_d;
            last_in_q     <= last_in_d;
            req_in_prev_q <= req_in;
            motor_up_q    <= (state_d == OPENING);
            motor_down_q  <= (state_d == CLOSING);
            open_q        <= (state_d == OPEN);
            inc_q         <= inc_d;
            dec_q         <= dec_d;
            reject_q      <= req_in & ~req_in_prev_q & lleno;
        end
    end

    assign grant_in     = grant_in_q;
    assign grant_out    = grant_out_q;
    assign motor_up     = motor_up_q;
    assign motor_down   = motor_down_q;
    assign gate_is_open = open_q;
    assign inc          = inc_q;
    assign dec          = dec_q;
    assign reject       = reject_q;
    assign estado       = state_q;

endmodule

// File: tb/tb_gate_arbiter.sv
// Vector-table bench for gate_arbiter: each record holds one cycle of inputs and
// the outputs expected right after that cycle's rising edge.
module tb_gate_arbiter;

   typedef struct packed {
      logic       grantIn;
      logic       grantOut;
      logic       motorUp;
      logic       motorDown;
      logic       gateOpen;
      logic       inc;
      logic       dec;
      logic       reject;
      logic [1:0] estado;
   } out_t;

   typedef struct {
      string      name;
      logic       rst;
      logic       ri;
      logic       ro;
      logic       pd;
      logic [2:0] cnt;
      logic       ll;
      out_t       exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       reqIn = 1'b0;
   logic       reqOut = 1'b0;
   logic       passDone = 1'b0;
   logic [2:0] count = 3'd0;
   logic       lleno = 1'b0;
   logic       grantIn, grantOut, motorUp, motorDown, gateIsOpen, incP, decP, reject;
   logic [1:0] estado;

   vec_t vecTable[$];
   out_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   gate_arbiter dut (
      .clk(clk),
      .reset(reset),
      .req_in(reqIn),
      .req_out(reqOut),
      .pass_done(passDone),
      .count(count),
      .lleno(lleno),
      .grant_in(grantIn),
      .grant_out(grantOut),
      .motor_up(motorUp),
      .motor_down(motorDown),
      .gate_is_open(gateIsOpen),
      .inc(incP),
      .dec(decP),
      .reject(reject),
      .estado(estado)
   );

   always #5 clk = ~clk;

   // Motor and open flags follow directly from the expected state.
   function automatic out_t mk(logic gi, logic go, logic [1:0] st, logic in_, logic de, logic rj);
      out_t o;
      o.grantIn   = gi;
      o.grantOut  = go;
      o.motorUp   = (st == 2'd1);
      o.motorDown = (st == 2'd3);
      o.gateOpen  = (st == 2'd2);
      o.inc       = in_;
      o.dec       = de;
      o.reject    = rj;
      o.estado    = st;
      return o;
   endfunction

   task automatic addVec(string name, logic rst, logic ri, logic ro, logic pd,
                         logic [2:0] cnt, logic ll, out_t e);
      vec_t v;
      v.name = name; v.rst = rst; v.ri = ri; v.ro = ro; v.pd = pd;
      v.cnt = cnt; v.ll = ll; v.exp = e;
      vecTable.push_back(v);
   endtask

   task automatic addReset(string name);
      addVec(name, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, mk(0, 0, 2'd0, 0, 0, 0));
   endtask

   // One full barrier transaction with request levels held throughout.
   task automatic addTxn(string name, logic ri, logic ro, logic [2:0] cnt, logic ll,
                         logic gin, int waitCycles, logic pdEnd, logic pdInClose);
      addVec({name, "_grant"}, 0, ri, ro, 0, cnt, ll, mk(gin, ~gin, 2'd1, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         addVec({name, "_opening"}, 0, ri, ro, 0, cnt, ll, mk(gin, ~gin, 2'd1, 0, 0, 0));
      addVec({name, "_open"}, 0, ri, ro, 0, cnt, ll, mk(gin, ~gin, 2'd2, 0, 0, 0));
      for (int i = 0; i < waitCycles; i++)
         addVec({name, "_wait"}, 0, ri, ro, 0, cnt, ll, mk(gin, ~gin, 2'd2, 0, 0, 0));
      addVec({name, "_leaveOpen"}, 0, ri, ro, pdEnd, cnt, ll,
             mk(gin, ~gin, 2'd3, pdEnd & gin, pdEnd & ~gin, 0));
      for (int i = 0; i < 3; i++)
         addVec({name, "_closing"}, 0, ri, ro, pdInClose, cnt, ll, mk(gin, ~gin, 2'd3, 0, 0, 0));
      addVec({name, "_idle"}, 0, ri, ro, pdInClose, cnt, ll, mk(0, 0, 2'd0, 0, 0, 0));
   endtask

   // Drive on the falling edge and queue what the next rising edge must produce.
   task automatic applyStimulus(vec_t v);
      @(negedge clk);
      reset    = v.rst;
      reqIn    = v.ri;
      reqOut   = v.ro;
      passDone = v.pd;
      count    = v.cnt;
      lleno    = v.ll;
      expQ.push_back(v.exp);
   endtask

   task automatic checkOutput(string name);
      out_t act, exp;
      @(posedge clk);
      #1;
      act = {grantIn, grantOut, motorUp, motorDown, gateIsOpen, incP, decP, reject, estado};
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s: no expected entry queued, got %b", name, act);
      end else begin
         exp = expQ.pop_front();
         if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got gi/go/up/dn/open/inc/dec/rej/st=%b required %b",
                     name, act, exp);
         end
      end
   endtask

   task automatic runVec(string name, logic rst, logic ri, logic ro, logic pd,
                         logic [2:0] cnt, logic ll, out_t e);
      vec_t v;
      v.name = name; v.rst = rst; v.ri = ri; v.ro = ro; v.pd = pd;
      v.cnt = cnt; v.ll = ll; v.exp = e;
      applyStimulus(v);
      checkOutput(name);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Basic entry, pass on the first open cycle, inc pulse.
      addReset("reset0");
      addTxn("entry", 1, 0, 3'd0, 0, 1, 0, 1, 0);
      addReset("reset1");

      // Tie: exit first after reset, then alternate while both are held.
      addTxn("tie1", 1, 1, 3'd3, 0, 0, 0, 1, 0);
      addTxn("tie2", 1, 1, 3'd3, 0, 1, 0, 1, 0);
      addTxn("tie3", 1, 1, 3'd3, 0, 0, 0, 1, 0);
      addReset("reset2");

      // Full lot: one reject per rising edge of req_in, never a grant.
      addVec("fullLow", 0, 0, 0, 0, 3'd7, 1, mk(0, 0, 2'd0, 0, 0, 0));
      addVec("fullRise", 0, 1, 0, 0, 3'd7, 1, mk(0, 0, 2'd0, 0, 0, 1));
      for (int i = 0; i < 3; i++)
         addVec("fullHeld", 0, 1, 0, 0, 3'd7, 1, mk(0, 0, 2'd0, 0, 0, 0));
      addVec("fullDrop", 0, 0, 0, 0, 3'd7, 1, mk(0, 0, 2'd0, 0, 0, 0));
      addVec("fullRise2", 0, 1, 0, 0, 3'd7, 1, mk(0, 0, 2'd0, 0, 0, 1));
      addReset("reset3");

      // Timeout with no pass, then pass in the very last timeout cycle.
      addTxn("timeout", 1, 0, 3'd0, 0, 1, 15, 0, 1);
      addReset("reset4");
      addTxn("lastCycle", 0, 1, 3'd2, 0, 0, 15, 1, 0);
      addReset("reset5");

      // Exit with empty lot is ignored; stray pass pulses in IDLE do nothing.
      for (int i = 0; i < 3; i++)
         addVec("emptyExit", 0, 0, 1, 0, 3'd0, 0, mk(0, 0, 2'd0, 0, 0, 0));
      addVec("idlePass", 0, 0, 0, 1, 3'd0, 0, mk(0, 0, 2'd0, 0, 0, 0));

      for (int i = 0; i < vecTable.size(); i++) begin
         applyStimulus(vecTable[i]);
         checkOutput(vecTable[i].name);
      end

      // Reset during OPEN, pass_done present in the same cycle: no inc.
      runVec("rstA", 1, 0, 0, 0, 3'd0, 0, mk(0, 0, 2'd0, 0, 0, 0));
      runVec("rA_grant", 0, 1, 0, 0, 3'd0, 0, mk(1, 0, 2'd1, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         runVec("rA_opening", 0, 1, 0, 0, 3'd0, 0, mk(1, 0, 2'd1, 0, 0, 0));
      runVec("rA_open", 0, 1, 0, 0, 3'd0, 0, mk(1, 0, 2'd2, 0, 0, 0));
      runVec("rA_resetInOpen", 1, 1, 0, 1, 3'd0, 0, mk(0, 0, 2'd0, 0, 0, 0));
      runVec("rA_regrant", 0, 1, 0, 0, 3'd0, 0, mk(1, 0, 2'd1, 0, 0, 0));
      runVec("rA_resetInOpening", 1, 1, 0, 0, 3'd0, 0, mk(0, 0, 2'd0, 0, 0, 0));
      runVec("rA_tieAfterReset", 0, 1, 1, 0, 3'd3, 0, mk(0, 1, 2'd1, 0, 0, 0));

      // Reject while the exit side holds the barrier; lleno does not abort it.
      runVec("rstB", 1, 0, 0, 0, 3'd0, 0, mk(0, 0, 2'd0, 0, 0, 0));
      runVec("rB_grantOut", 0, 0, 1, 0, 3'd3, 0, mk(0, 1, 2'd1, 0, 0, 0));
      runVec("rB_rejectBusy", 0, 1, 1, 0, 3'd3, 1, mk(0, 1, 2'd1, 0, 0, 1));
      runVec("rB_opening", 0, 1, 1, 0, 3'd3, 1, mk(0, 1, 2'd1, 0, 0, 0));
      runVec("rB_opening2", 0, 1, 1, 0, 3'd3, 1, mk(0, 1, 2'd1, 0, 0, 0));
      runVec("rB_open", 0, 1, 1, 0, 3'd3, 1, mk(0, 1, 2'd2, 0, 0, 0));
      runVec("rB_pass", 0, 1, 1, 1, 3'd3, 1, mk(0, 1, 2'd3, 0, 1, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
